// File: rtl/store_lane_buffer.sv
// Store path from MEM to the data-memory port: byte-enable/lane decode, AdES
// detection, and a DEPTH-entry FIFO drained through a req/ack handshake.
module store_lane_buffer #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DEPTH  = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   st_valid,
  input  logic [1:0]             st_size,
  input  logic [ADDR_W-1:0]      st_addr,
  input  logic [DATA_W-1:0]      st_wdata,
  output logic                   st_ready,
  output logic                   st_exc,
  output logic                   mem_req,
  output logic [ADDR_W-1:0]      mem_addr,
  output logic [DATA_W/8-1:0]    mem_be,
  output logic [DATA_W-1:0]      mem_wdata,
  input  logic                   mem_ack,
  output logic                   buf_empty
);

  localparam int unsigned BYTES = DATA_W / 8;
  localparam int unsigned OFF_W = $clog2(BYTES);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [OFF_W-1:0]  off;
  logic [OFF_W-1:0]  align_mask;
  logic [BYTES-1:0]  be_base;
  logic [BYTES-1:0]  be_c;
  logic [DATA_W-1:0] data_mask;
  logic [DATA_W-1:0] wdata_c;
  logic              illegal;
  logic              misaligned;
  logic              full;
  logic              enq;
  logic              deq;

  logic [PTR_W-1:0]  head;
  logic [PTR_W-1:0]  tail;
  logic [CNT_W-1:0]  count;
  logic [CNT_W-1:0]  count_next;
  logic              empty_q;

  logic [ADDR_W-1:0] addr_q [DEPTH];
  logic [BYTES-1:0]  be_q   [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];

  // Size decode: unshifted enable pattern and the offset bits that must be zero
  always_comb begin
    off        = st_addr[OFF_W-1:0];
    be_base    = '0;
    align_mask = '0;
    illegal    = 1'b0;
    data_mask  = '0;
    case (st_size)
      2'b01: be_base = BYTES'(1);
      2'b10: begin
        be_base    = BYTES'(3);
        align_mask = OFF_W'(1);
      end
      2'b00: begin
        be_base    = BYTES'(15);
        align_mask = OFF_W'(3);
      end
      default: begin
        be_base    = BYTES'(8'hFF);
        align_mask = OFF_W'(7);
        illegal    = (BYTES < 8);
      end
    endcase
    for (int unsigned i = 0; i < BYTES; i++) begin
      data_mask[8*i +: 8] = {8{be_base[i]}};
    end
    misaligned = |(off & align_mask);
    be_c       = be_base << off;
    wdata_c    = (st_wdata & data_mask) << {off, 3'b000};
  end

  assign st_exc     = st_valid & (misaligned | illegal);
  assign full       = (count == CNT_W'(DEPTH));
  assign st_ready   = !full;
  assign enq        = st_valid & st_ready & !st_exc;
  assign deq        = !empty_q & mem_ack;
  assign count_next = count + CNT_W'(enq) - CNT_W'(deq);

  // Payload storage; contents are don't-care until written
  always_ff @(posedge clk) begin
    if (enq && !reset) begin
      addr_q[tail] <= {st_addr[ADDR_W-1:OFF_W], OFF_W'(0)};
      be_q[tail]   <= be_c;
      data_q[tail] <= wdata_c;
    end
  end

  // Pointers wrap naturally since DEPTH is a power of two
  always_ff @(posedge clk) begin
    if (reset) begin
      head    <= '0;
      tail    <= '0;
      count   <= '0;
      empty_q <= 1'b1;
    end else begin
      if (enq) tail <= tail + PTR_W'(1);
      if (deq) head <= head + PTR_W'(1);
      count   <= count_next;
      empty_q <= (count_next == '0);
    end
  end

  assign mem_req   = !empty_q;
  assign buf_empty = empty_q;
  assign mem_addr  = empty_q ? '0 : addr_q[head];
  assign mem_be    = empty_q ? '0 : be_q[head];
  assign mem_wdata = empty_q ? '0 : data_q[head];

endmodule
